// File: rtl/mpu_pkg.sv
// Shared MPU definitions: sequencer state encoding, program-counter width and
// the shift that turns a decoder nibble into a jump target.
package mpu_pkg;

  localparam int PC_W      = 8;
  localparam int JMP_SHIFT = 4;
  localparam int NIB_W     = PC_W - JMP_SHIFT;

  typedef logic [PC_W-1:0] pc_t;

  typedef enum logic [1:0] {
    S_RST  = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2,
    S_STEP = 2'd3
  } ps_state_e;

  // Jump targets are always aligned to a 16-instruction page.
  function automatic pc_t jump_target(input logic [NIB_W-1:0] nib);
    return {nib, {JMP_SHIFT{1'b0}}};
  endfunction

endpackage

// File: rtl/program_sequencer_if.sv
// Sequencer bundle: decoder/ALU/debug inputs plus the sequencer's address,
// status and synchronised-reset outputs.
interface program_sequencer_if;
  import mpu_pkg::*;

  logic             jmp;
  logic             jmp_nz;
  logic [NIB_W-1:0] jmp_addr;
  logic             dont_jmp;
  logic             halt_req;
  logic             step_req;

  logic             sync_reset;
  pc_t              pm_addr;
  pc_t              pc;
  logic             exec_en;
  logic             halted;
  pc_t              from_PS;

  modport master (
    input  jmp, jmp_nz, jmp_addr, dont_jmp, halt_req, step_req,
    output sync_reset, pm_addr, pc, exec_en, halted, from_PS
  );

  modport slave (
    output jmp, jmp_nz, jmp_addr, dont_jmp, halt_req, step_req,
    input  sync_reset, pm_addr, pc, exec_en, halted, from_PS
  );

endinterface

// File: rtl/reset_sync.sv
// Two-flop reset synchroniser: asserts asynchronously, releases on the
// second rising edge after reset falls.
module reset_sync (
  input  logic clk,
  input  logic reset,
  output logic sync_reset_o
);

  logic [1:0] sync_q;

  // NOTE: sequential state uses non-blocking assignments so both stages
  // sample their inputs before either one updates.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], 1'b0};
  end

  assign sync_reset_o = sync_q[1];

endmodule

// File: rtl/program_sequencer.sv
// Program sequencer: computes the next program-memory address and registers
// the PC. Debug halt/single-step is built only with PS_DEBUG_STEP_EN defined.
module program_sequencer
  import mpu_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  program_sequencer_if.master bus
);

  ps_state_e state_q, state_d;
  pc_t       pc_q, pc_d;
  logic      sync_reset;
  logic      exec_en;
  logic      halted;

  reset_sync u_reset_sync (
    .clk          (clk),
    .reset        (reset),
    .sync_reset_o (sync_reset)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_RST;
    else       state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first so no path
  // through the case statement can infer a latch.
  always_comb begin
    state_d = state_q;
    if (sync_reset) begin
      state_d = S_RST;
    end else begin
      case (state_q)
        S_RST:   state_d = S_RUN;
`ifdef PS_DEBUG_STEP_EN
        S_RUN:   if (bus.halt_req) state_d = S_HALT;
        // Resume takes priority over a step request.
        S_HALT: begin
          if (!bus.halt_req)     state_d = S_RUN;
          else if (bus.step_req) state_d = S_STEP;
        end
        S_STEP:  state_d = bus.halt_req ? S_HALT : S_RUN;
`else
        default: state_d = S_RUN;
`endif
      endcase
    end
  end

  always_comb begin
    exec_en = 1'b0;
    halted  = 1'b0;
    case (state_q)
      S_RUN:   exec_en = 1'b1;
`ifdef PS_DEBUG_STEP_EN
      S_STEP:  exec_en = 1'b1;
      S_HALT:  halted  = 1'b1;
`endif
      default: ;
    endcase
  end

  // Next address; the jump target reaches pm_addr in the same cycle.
  always_comb begin
    pc_d = pc_q + PC_W'(1);
    if (sync_reset)
      pc_d = '0;
`ifdef PS_DEBUG_STEP_EN
    else if (halted)
      pc_d = pc_q;
`endif
    else if (exec_en && bus.jmp)
      pc_d = jump_target(bus.jmp_addr);
    else if (exec_en && bus.jmp_nz && !bus.dont_jmp)
      pc_d = jump_target(bus.jmp_addr);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pc_q <= '0;
    else       pc_q <= pc_d;
  end

`ifndef PS_DEBUG_STEP_EN
  logic unused_dbg;
  assign unused_dbg = bus.halt_req ^ bus.step_req;
`endif

  assign bus.sync_reset = sync_reset;
  assign bus.pm_addr    = pc_d;
  assign bus.pc         = pc_q;
  assign bus.exec_en    = exec_en;
  assign bus.halted     = halted;
  assign bus.from_PS    = pc_q;

endmodule

// File: tb/tb_program_sequencer.sv
// Self-checking bench for program_sequencer: directed reset/jump/wrap/debug
// scenarios followed by randomized stimulus against a behavioural model.
module tb_program_sequencer;
  import mpu_pkg::*;

  logic clk = 1'b0;
  logic reset;

  program_sequencer_if ps_if ();

  program_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ps_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

`ifdef PS_DEBUG_STEP_EN
  localparam bit DBG = 1'b1;
`else
  localparam bit DBG = 1'b0;
`endif

  typedef struct packed {
    logic       rst;
    logic       jmp;
    logic       jnz;
    logic [3:0] addr;
    logic       dont;
    logic       halt;
    logic       step;
  } stim_t;

  function automatic stim_t mk(bit rst, bit jmp, bit jnz, logic [3:0] addr,
                               bit dont, bit halt, bit step);
    stim_t s;
    s.rst = rst; s.jmp = jmp; s.jnz = jnz; s.addr = addr;
    s.dont = dont; s.halt = halt; s.step = step;
    return s;
  endfunction

  // Reference model: operating mode, PC, and edges seen since reset release.
  typedef enum int {M_BOOT, M_RUN, M_HALT, M_STEP} mode_e;
  mode_e m_mode;
  int    m_pc;
  int    m_edges;
  stim_t cur;

  function automatic bit exp_sync();
    return reset || (m_edges < 2);
  endfunction

  function automatic bit exp_exec();
    return !reset && (m_mode == M_RUN || m_mode == M_STEP);
  endfunction

  function automatic bit exp_halted();
    return !reset && (m_mode == M_HALT);
  endfunction

  function automatic int exp_pm();
    if (exp_sync()) return 0;
    if (m_mode == M_HALT) return m_pc;
    if (exp_exec() && (cur.jmp || (cur.jnz && !cur.dont))) return int'(cur.addr) * 16;
    return (m_pc + 1) % 256;
  endfunction

  task automatic model_reset();
    m_pc = 0; m_edges = 0; m_mode = M_BOOT;
  endtask

  task automatic advance();
    int    nxt_pc;
    bit    was_sync;
    mode_e nm;
    if (reset) begin
      model_reset();
      return;
    end
    nxt_pc   = exp_pm();
    was_sync = exp_sync();
    nm       = m_mode;
    case (m_mode)
      M_BOOT: if (!was_sync) nm = M_RUN;
      M_RUN:  if (DBG && cur.halt) nm = M_HALT;
      M_HALT: if (!cur.halt) nm = M_RUN; else if (cur.step) nm = M_STEP;
      M_STEP: nm = cur.halt ? M_HALT : M_RUN;
      default: ;
    endcase
    m_pc   = nxt_pc;
    m_mode = nm;
    if (m_edges < 2) m_edges++;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".pm_addr"},    ps_if.pm_addr,    exp_pm());
    check({tag, ".pc"},         ps_if.pc,         m_pc);
    check({tag, ".from_PS"},    ps_if.from_PS,    m_pc);
    check({tag, ".exec_en"},    ps_if.exec_en,    exp_exec());
    check({tag, ".halted"},     ps_if.halted,     exp_halted());
    check({tag, ".sync_reset"}, ps_if.sync_reset, exp_sync());
  endtask

  task automatic drive(input stim_t s);
    @(negedge clk);
    cur = s;
    ps_if.jmp      = s.jmp;
    ps_if.jmp_nz   = s.jnz;
    ps_if.jmp_addr = s.addr;
    ps_if.dont_jmp = s.dont;
    ps_if.halt_req = s.halt;
    ps_if.step_req = s.step;
    if (s.rst) model_reset();
    reset = s.rst;
    #1;
  endtask

  task automatic tick(input bit mid_rst);
    if (mid_rst) begin
      #2;
      reset = 1'b1;
      model_reset();
      #1;
      check_outputs("mid_reset");
    end
    @(posedge clk);
    advance();
  endtask

  task automatic cycle(input stim_t s, input string tag);
    drive(s);
    check_outputs(tag);
    tick(1'b0);
  endtask

  stim_t idle;
  int    rst_hold;
  bit    halt_lvl;

  initial begin
    idle = mk(0, 0, 0, 4'h0, 0, 0, 0);
    reset = 1'b1;
    cur = mk(1, 0, 0, 4'h0, 0, 0, 0);
    ps_if.jmp = 1'b0; ps_if.jmp_nz = 1'b0; ps_if.jmp_addr = 4'h0;
    ps_if.dont_jmp = 1'b0; ps_if.halt_req = 1'b0; ps_if.step_req = 1'b0;
    model_reset();

    // Reset held: everything forced to its idle value.
    for (int i = 0; i < 3; i++) begin
      drive(mk(1, 1, 0, 4'h7, 0, 0, 0));
      check_outputs("reset");
      check("reset.pm_const", ps_if.pm_addr, 8'h00);
      check("reset.sync_const", ps_if.sync_reset, 1'b1);
      tick(1'b0);
    end

    // Release: sync_reset stays high for two edges, then pm_addr counts up.
    for (int i = 0; i < 2; i++) begin
      drive(idle);
      check_outputs("release");
      check("release.sync_held", ps_if.sync_reset, 1'b1);
      tick(1'b0);
    end
    drive(idle);
    check_outputs("release");
    check("release.sync_low", ps_if.sync_reset, 1'b0);
    check("release.pm_first", ps_if.pm_addr, 8'h01);
    tick(1'b0);
    for (int i = 0; i < 20 && m_pc != 5; i++) cycle(idle, "count");

    // Unconditional jump from pc=05.
    drive(mk(0, 1, 0, 4'h3, 0, 0, 0));
    check_outputs("jmp");
    check("jmp.pc_before", ps_if.pc, 8'h05);
    check("jmp.pm_target", ps_if.pm_addr, 8'h30);
    tick(1'b0);
    drive(mk(0, 0, 1, 4'hA, 1, 0, 0));
    check_outputs("jnz_taken_off");
    check("jmp.pc_after", ps_if.pc, 8'h30);
    check("jnz.suppressed", ps_if.pm_addr, 8'h31);
    tick(1'b0);
    drive(mk(0, 0, 1, 4'hA, 0, 0, 0));
    check_outputs("jnz_taken");
    check("jnz.target", ps_if.pm_addr, 8'hA0);
    tick(1'b0);
    drive(mk(0, 1, 1, 4'h5, 1, 0, 0));
    check_outputs("jmp_over_jnz");
    check("jmp_over_jnz.target", ps_if.pm_addr, 8'h50);
    tick(1'b0);

    // Wrap: jump to F0, then count to FF.
    cycle(mk(0, 1, 0, 4'hF, 0, 0, 0), "to_f0");
    for (int i = 0; i < 20 && m_pc != 255; i++) cycle(idle, "to_ff");
    drive(idle);
    check_outputs("wrap");
    check("wrap.pc", ps_if.pc, 8'hFF);
    check("wrap.pm", ps_if.pm_addr, 8'h00);
    tick(1'b0);

`ifdef PS_DEBUG_STEP_EN
    // Halt at pc=10, hold, single step, then step+resume together.
    cycle(mk(0, 1, 0, 4'h1, 0, 0, 0), "to_10");
    drive(mk(0, 0, 0, 4'h0, 0, 1, 0));
    check_outputs("halt_req");
    check("halt.pc", ps_if.pc, 8'h10);
    tick(1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(mk(0, 0, 0, 4'h0, 0, 1, 0));
      check_outputs("halted");
      check("halted.pc", ps_if.pc, 8'h11);
      check("halted.exec", ps_if.exec_en, 1'b0);
      check("halted.flag", ps_if.halted, 1'b1);
      tick(1'b0);
    end
    cycle(mk(0, 0, 0, 4'h0, 0, 1, 1), "step_req");
    drive(mk(0, 0, 0, 4'h0, 0, 1, 0));
    check_outputs("stepping");
    check("step.exec", ps_if.exec_en, 1'b1);
    check("step.pm", ps_if.pm_addr, 8'h12);
    tick(1'b0);
    drive(mk(0, 0, 0, 4'h0, 0, 1, 0));
    check_outputs("after_step");
    check("after_step.pc", ps_if.pc, 8'h12);
    check("after_step.exec", ps_if.exec_en, 1'b0);
    tick(1'b0);
    cycle(mk(0, 0, 0, 4'h0, 0, 0, 1), "resume_step");
    drive(idle);
    check_outputs("resumed");
    check("resumed.halted", ps_if.halted, 1'b0);
    check("resumed.exec", ps_if.exec_en, 1'b1);
    tick(1'b0);

    // Reset during S_STEP.
    cycle(mk(0, 0, 0, 4'h0, 0, 1, 0), "halt2");
    cycle(mk(0, 0, 0, 4'h0, 0, 1, 1), "step2_req");
    drive(mk(0, 0, 0, 4'h0, 0, 1, 0));
    check_outputs("step2");
    tick(1'b1);
    check("step_rst.pc", ps_if.pc, 8'h00);
    check("step_rst.sync", ps_if.sync_reset, 1'b1);
`else
    // Reset mid-run; halt/step requests must be ignored throughout.
    cycle(mk(0, 0, 0, 4'h0, 0, 1, 1), "ignored_dbg");
    drive(mk(0, 0, 0, 4'h0, 0, 1, 0));
    check_outputs("run_rst");
    check("nodbg.halted", ps_if.halted, 1'b0);
    tick(1'b1);
    check("run_rst.pc", ps_if.pc, 8'h00);
    check("run_rst.sync", ps_if.sync_reset, 1'b1);
`endif
    for (int i = 0; i < 2; i++) begin
      drive(mk(1, 0, 0, 4'h0, 0, 1, 1));
      check_outputs("rst_hold");
      check("rst_hold.exec", ps_if.exec_en, 1'b0);
      tick(1'b0);
    end

    // Randomized phase.
    rst_hold = 0;
    halt_lvl = 1'b0;
    for (int i = 0; i < 400; i++) begin
      stim_t s;
      bit    mid;
      if ($urandom_range(0, 7) == 0) halt_lvl = ~halt_lvl;
      if (rst_hold == 0 && $urandom_range(0, 59) == 0) rst_hold = $urandom_range(1, 3);
      s = mk(rst_hold > 0, $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
             4'($urandom_range(0, 15)), $urandom_range(0, 1) == 1, halt_lvl,
             $urandom_range(0, 3) == 0);
      if (rst_hold > 0) rst_hold--;
      mid = (s.rst == 1'b0) && ($urandom_range(0, 79) == 0);
      drive(s);
      check_outputs("random");
      tick(mid);
      if (mid) rst_hold = 2;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
